// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes, row encodings and the shared key-to-matrix table
package keypad_pkg;

    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;
    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    localparam logic [3:0] ROW_123 = 4'b0001;
    localparam logic [3:0] ROW_456 = 4'b0010;
    localparam logic [3:0] ROW_789 = 4'b0100;
    localparam logic [3:0] ROW_S0H = 4'b1000;

    typedef enum logic [1:0] {ST_IDLE, ST_PRESS, ST_RELEASE} emu_state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] row;
        logic [1:0] col;
    } rowcol_t;

    // Matrix position of a key code; codes 12-15 come back with valid = 0
    function automatic rowcol_t key_to_rowcol(input logic [3:0] code);
        rowcol_t rc;
        rc = '0;
        case (code)
            KEY_1:    rc = '{1'b1, 2'd0, 2'd0};
            KEY_2:    rc = '{1'b1, 2'd0, 2'd1};
            KEY_3:    rc = '{1'b1, 2'd0, 2'd2};
            KEY_4:    rc = '{1'b1, 2'd1, 2'd0};
            KEY_5:    rc = '{1'b1, 2'd1, 2'd1};
            KEY_6:    rc = '{1'b1, 2'd1, 2'd2};
            KEY_7:    rc = '{1'b1, 2'd2, 2'd0};
            KEY_8:    rc = '{1'b1, 2'd2, 2'd1};
            KEY_9:    rc = '{1'b1, 2'd2, 2'd2};
            KEY_STAR: rc = '{1'b1, 2'd3, 2'd0};
            KEY_0:    rc = '{1'b1, 2'd3, 2'd1};
            KEY_HASH: rc = '{1'b1, 2'd3, 2'd2};
            default:  rc = '0;
        endcase
        return rc;
    endfunction

    // One-hot row drive pattern for a row index
    function automatic logic [3:0] row_onehot(input logic [1:0] row);
        return (row == 2'd0) ? ROW_123 :
               (row == 2'd1) ? ROW_456 :
               (row == 2'd2) ? ROW_789 : ROW_S0H;
    endfunction

endpackage

// File: rtl/keypad_emu_fifo.sv
// keypad_emu_fifo: synchronous FIFO holding queued key codes
module keypad_emu_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage array; contents need no reset since level gates reads
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers and occupancy; simultaneous push and pop leave level unchanged
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/keypad3c4r_emu.sv
// keypad3c4r_emu: replays queued key codes onto a 3x4 keypad matrix for the scanner
module keypad3c4r_emu
    import keypad_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 16,
    parameter int HOLD_CYCLES = 2000,
    parameter int GAP_CYCLES  = 2000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [3:0]                    key_code,
    input  logic                          key_valid,
    output logic                          key_ready,
    input  logic [3:0]                    keypadr,
    output logic [2:0]                    keypadc,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          err
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if (HOLD_CYCLES < 1 || longint'(HOLD_CYCLES) > (64'd1 << CNT_W)) begin : g_bad_hold
        $error("HOLD_CYCLES must be >= 1 and fit CNT_W");
    end
    if (GAP_CYCLES < 1 || longint'(GAP_CYCLES) > (64'd1 << CNT_W)) begin : g_bad_gap
        $error("GAP_CYCLES must be >= 1 and fit CNT_W");
    end

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    emu_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       cur_key;
    logic [3:0]       fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    rowcol_t          rc;

    assign push      = key_valid && !fifo_full;
    assign pop       = en && (state == ST_IDLE) && !fifo_empty;
    assign key_ready = !fifo_full;
    assign busy      = (state != ST_IDLE) || !fifo_empty;

    keypad_emu_fifo #(.DEPTH(FIFO_DEPTH), .W(4)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (key_code),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Press/release sequencer; en low freezes both state and counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            cur_key <= 4'd15;
        end else if (en) begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cur_key <= fifo_rdata;
                        cnt     <= '0;
                        state   <= ST_PRESS;
                    end
                end
                ST_PRESS: begin
                    if (cnt == HOLD_LAST) begin
                        cnt   <= '0;
                        state <= ST_RELEASE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky flag for any accepted code outside the 12-key set
    always_ff @(posedge clk) begin
        if (!rst_n) err <= 1'b0;
        else if (push && key_code > KEY_HASH) err <= 1'b1;
    end

    // Column return follows the row drive combinationally so the scanner sees it same-cycle
    always_comb begin
        rc      = key_to_rowcol(cur_key);
        keypadc = (rc.valid && state == ST_PRESS && |(keypadr & row_onehot(rc.row)))
                  ? (3'b001 << rc.col) : 3'b000;
    end

endmodule

// File: tb/tb_keypad3c4r_emu.sv
// tb_keypad3c4r_emu: directed checks of keypad replay timing, matrix, queueing and reset
module tb_keypad3c4r_emu;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic [3:0] keypadr;
    logic [2:0] keypadc;
    logic       key_ready;
    logic       busy;
    logic       err;
    logic [2:0] fifo_level;
    logic [1:0] rot = 2'd0;
    int         checks = 0;
    int         failures = 0;
    logic [3:0] seq [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};

    always #5 clk = ~clk;

    always @(posedge clk) rot <= rot + 2'd1;

    assign keypadr = 4'b0001 << rot;

    keypad3c4r_emu #(.FIFO_DEPTH(4), .CNT_W(16), .HOLD_CYCLES(4), .GAP_CYCLES(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .keypadr    (keypadr),
        .keypadc    (keypadc),
        .busy       (busy),
        .fifo_level (fifo_level),
        .err        (err)
    );

    function automatic logic [2:0] exp_col(input logic [3:0] k, input logic [3:0] r);
        logic [3:0] rr;
        logic [2:0] cc;
        case (k)
            4'd1:    begin rr = 4'b0001; cc = 3'b001; end
            4'd2:    begin rr = 4'b0001; cc = 3'b010; end
            4'd3:    begin rr = 4'b0001; cc = 3'b100; end
            4'd4:    begin rr = 4'b0010; cc = 3'b001; end
            4'd5:    begin rr = 4'b0010; cc = 3'b010; end
            4'd6:    begin rr = 4'b0010; cc = 3'b100; end
            4'd7:    begin rr = 4'b0100; cc = 3'b001; end
            4'd8:    begin rr = 4'b0100; cc = 3'b010; end
            4'd9:    begin rr = 4'b0100; cc = 3'b100; end
            4'd10:   begin rr = 4'b1000; cc = 3'b001; end
            4'd0:    begin rr = 4'b1000; cc = 3'b010; end
            4'd11:   begin rr = 4'b1000; cc = 3'b100; end
            default: begin rr = 4'b0000; cc = 3'b000; end
        endcase
        return (|(rr & r)) ? cc : 3'b000;
    endfunction

    task test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (key_ready !== 1'b1) begin failures++; $display("FAIL reset_ready i=%0d got=%b exp=1", i, key_ready); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy i=%0d got=%b exp=0", i, busy); end
            checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level i=%0d got=%0d exp=0", i, fifo_level); end
            checks++; if (keypadc !== 3'b000) begin failures++; $display("FAIL reset_col i=%0d row=%b got=%b exp=000", i, keypadr, keypadc); end
            checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err i=%0d got=%b exp=0", i, err); end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task test_single_press;
        logic [2:0] e;
        key_valid = 1'b1; key_code = 4'd5;
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            key_valid = 1'b0;
            e = (k >= 1 && k <= 4 && keypadr == 4'b0010) ? 3'b010 : 3'b000;
            checks++; if (keypadc !== e) begin failures++; $display("FAIL single_col k=%0d row=%b got=%b exp=%b", k, keypadr, keypadc, e); end
            checks++; if (busy !== (k < 8)) begin failures++; $display("FAIL single_busy k=%0d got=%b exp=%b", k, busy, k < 8); end
        end
    endtask

    task test_back_to_back;
        logic [2:0] e;
        key_valid = 1'b1; key_code = 4'd11;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            e = (k >= 1 && k <= 4 && keypadr == 4'b1000) ? 3'b100 :
                (k >= 9 && k <= 12 && keypadr == 4'b1000) ? 3'b001 : 3'b000;
            checks++; if (keypadc !== e) begin failures++; $display("FAIL b2b_col k=%0d row=%b got=%b exp=%b", k, keypadr, keypadc, e); end
            checks++; if (busy !== (k < 16)) begin failures++; $display("FAIL b2b_busy k=%0d got=%b exp=%b", k, busy, k < 16); end
            if (k == 0) key_code = 4'd10;
            else key_valid = 1'b0;
        end
    endtask

    task test_fifo_full;
        logic [2:0] e;
        int lvl;
        int j;
        key_valid = 1'b1; key_code = seq[0];
        for (int k = 0; k <= 41; k++) begin
            @(negedge clk);
            lvl = (k == 0) ? 1 : (k <= 4) ? k : (k < 9) ? 4 : (k < 17) ? 3 : (k < 25) ? 2 : (k < 33) ? 1 : 0;
            j = (k - 1) / 8;
            e = (k >= 1 && j < 5 && ((k - 1) % 8) < 4) ? exp_col(seq[j], keypadr) : 3'b000;
            checks++; if (fifo_level !== 3'(lvl)) begin failures++; $display("FAIL full_level k=%0d got=%0d exp=%0d", k, fifo_level, lvl); end
            checks++; if (key_ready !== (lvl != 4)) begin failures++; $display("FAIL full_ready k=%0d got=%b exp=%b", k, key_ready, lvl != 4); end
            checks++; if (keypadc !== e) begin failures++; $display("FAIL full_col k=%0d row=%b got=%b exp=%b", k, keypadr, keypadc, e); end
            checks++; if (busy !== (k < 40)) begin failures++; $display("FAIL full_busy k=%0d got=%b exp=%b", k, busy, k < 40); end
            if (k < 4) key_code = seq[k + 1];
            else key_valid = 1'b0;
        end
    endtask

    task test_invalid;
        logic [2:0] e;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL inv_err_pre got=%b exp=0", err); end
        key_valid = 1'b1; key_code = 4'd13;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            e = (k >= 9 && k <= 12) ? exp_col(4'd0, keypadr) : 3'b000;
            checks++; if (err !== 1'b1) begin failures++; $display("FAIL inv_err k=%0d got=%b exp=1", k, err); end
            checks++; if (keypadc !== e) begin failures++; $display("FAIL inv_col k=%0d row=%b got=%b exp=%b", k, keypadr, keypadc, e); end
            checks++; if (busy !== (k < 16)) begin failures++; $display("FAIL inv_busy k=%0d got=%b exp=%b", k, busy, k < 16); end
            if (k == 0) key_code = 4'd0;
            else key_valid = 1'b0;
        end
    endtask

    task test_en_freeze;
        logic [2:0] e;
        key_valid = 1'b1; key_code = 4'd7; en = 1'b1;
        for (int k = 0; k <= 19; k++) begin
            @(negedge clk);
            e = (k >= 1 && k <= 14 && keypadr == 4'b0100) ? 3'b001 : 3'b000;
            checks++; if (keypadc !== e) begin failures++; $display("FAIL en_col k=%0d row=%b got=%b exp=%b", k, keypadr, keypadc, e); end
            checks++; if (busy !== (k < 18)) begin failures++; $display("FAIL en_busy k=%0d got=%b exp=%b", k, busy, k < 18); end
            key_valid = 1'b0;
            en = !(k >= 2 && k <= 11);
        end
        en = 1'b1;
    endtask

    task test_reset_mid;
        key_valid = 1'b1; key_code = 4'd3;
        @(negedge clk);
        key_code = 4'd4;
        @(negedge clk);
        key_code = 4'd5;
        @(negedge clk);
        key_valid = 1'b0;
        checks++; if (keypadc !== exp_col(4'd3, keypadr)) begin failures++; $display("FAIL rmid_pre_col row=%b got=%b exp=%b", keypadr, keypadc, exp_col(4'd3, keypadr)); end
        checks++; if (fifo_level !== 3'd2) begin failures++; $display("FAIL rmid_pre_level got=%0d exp=2", fifo_level); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (keypadc !== 3'b000) begin failures++; $display("FAIL rmid_col got=%b exp=000", keypadc); end
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL rmid_level got=%0d exp=0", fifo_level); end
        checks++; if (key_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", key_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rmid_err got=%b exp=0", err); end
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++; if (keypadc !== 3'b000) begin failures++; $display("FAIL rmid_after_col k=%0d row=%b got=%b exp=000", k, keypadr, keypadc); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_after_busy k=%0d got=%b exp=0", k, busy); end
        end
    endtask

    initial begin
        test_reset;
        test_single_press;
        test_back_to_back;
        test_fifo_full;
        test_invalid;
        test_en_freeze;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
